secure_vote_ctrl: RTL

- Parametrised single-clock successor to the four-candidate password-gated voting counter.
- Authenticates a multi-digit PIN against a reference PIN.
- Allows exactly one vote per successful authentication and keeps saturating per-candidate tallies.
- Locks out after repeated PIN failures and reports all leading candidates (ties included) in display mode. Sits between the keypad/button front-end and the result display.

---
 rtl/secure_vote_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/secure_vote_ctrl.sv
// secure_vote_ctrl: PIN-gated voting controller with saturating per-candidate
// tallies, lockout after repeated PIN failures and a tie-aware leader display.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   pin_in     entered PIN, digit 0 in the LSBs
//   pin_ref    reference PIN (static)
//   pin_valid  one-cycle strobe: pin_in is ready to check
//   vote_btn   candidate buttons, one bit per candidate
//   display    level: show results
//   unlock     administrator strobe: clears lockout
//   tally      candidate i count at [i*CNT_W +: CNT_W]
//   winner     candidates holding the maximum tally (RESULT only)
//   auth_ok    high while authenticated
//   locked     high while locked out
//   vote_ack   one-cycle pulse: vote accepted
//   vote_err   one-cycle pulse: vote rejected (multi-press or saturated)
//   pin_fail   one-cycle pulse: PIN mismatch
module secure_vote_ctrl #(
  parameter int unsigned N_CAND       = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned PIN_DIGITS   = 4,
  parameter int unsigned DIGIT_W      = 4,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned AUTH_TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIN_DIGITS*DIGIT_W-1:0]    pin_in,
  input  logic [PIN_DIGITS*DIGIT_W-1:0]    pin_ref,
  input  logic                             pin_valid,
  input  logic [N_CAND-1:0]                vote_btn,
  input  logic                             display,
  input  logic                             unlock,
  output logic [N_CAND*CNT_W-1:0]          tally,
  output logic [N_CAND-1:0]                winner,
  output logic                             auth_ok,
  output logic                             locked,
  output logic                             vote_ack,
  output logic                             vote_err,
  output logic                             pin_fail
);

  localparam int unsigned TMO_W  = $clog2(AUTH_TIMEOUT + 1);
  localparam int unsigned FAIL_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_AUTH   = 2'd1,
    S_LOCKED = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    tally_q [N_CAND];
  logic [CNT_W-1:0]    tally_d [N_CAND];
  logic [N_CAND-1:0]   winner_q, winner_d;
  logic                auth_ok_q, auth_ok_d;
  logic                locked_q, locked_d;
  logic                vote_ack_q, vote_ack_d;
  logic                vote_err_q, vote_err_d;
  logic                pin_fail_q, pin_fail_d;

  logic                pin_match_c;
  logic                btn_single_c;
  logic                btn_multi_c;
  logic                sat_hit_c;
  logic [FAIL_W-1:0]   fail_inc_c;
  logic [CNT_W-1:0]    max_c;
  logic [N_CAND-1:0]   lead_c;

  // Input qualification: full-PIN compare, button pattern, saturation of the pressed candidate
  always_comb begin
    pin_match_c  = (pin_in == pin_ref);
    btn_single_c = (vote_btn != '0) && ((vote_btn & (vote_btn - N_CAND'(1))) == '0);
    btn_multi_c  = (vote_btn != '0) && !btn_single_c;
    sat_hit_c    = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      if (vote_btn[i] && (tally_q[i] == CNT_MAX)) sat_hit_c = 1'b1;
    end
    fail_inc_c = fail_q + FAIL_W'(1);
  end

  // Leader set: every candidate whose tally equals the maximum (ties all flagged)
  always_comb begin
    max_c  = '0;
    lead_c = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (tally_q[i] > max_c) max_c = tally_q[i];
    end
    for (int i = 0; i < N_CAND; i++) begin
      lead_c[i] = (tally_q[i] == max_c);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    tmo_d      = tmo_q;
    tally_d    = tally_q;
    vote_ack_d = 1'b0;
    vote_err_d = 1'b0;
    pin_fail_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (display) begin
          state_d = S_RESULT;
        end else if (pin_valid) begin
          if (pin_match_c) begin
            state_d = S_AUTH;
            fail_d  = '0;
            tmo_d   = TMO_W'(AUTH_TIMEOUT);
          end else begin
            pin_fail_d = 1'b1;
            fail_d     = fail_inc_c;
            if (fail_inc_c >= FAIL_W'(MAX_TRIES)) state_d = S_LOCKED;
          end
        end
      end

      S_AUTH: begin
        if (btn_single_c) begin
          // A single press always consumes the session, accepted or not
          state_d = S_IDLE;
          if (sat_hit_c) begin
            vote_err_d = 1'b1;
          end else begin
            vote_ack_d = 1'b1;
            for (int i = 0; i < N_CAND; i++) begin
              if (vote_btn[i]) tally_d[i] = tally_q[i] + CNT_W'(1);
            end
          end
        end else begin
          // Multi-press is rejected but the session timer keeps running
          vote_err_d = btn_multi_c;
          if (tmo_q <= TMO_W'(1)) begin
            tmo_d   = '0;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
        end
      end

      S_LOCKED: begin
        if (unlock) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end
      end

      S_RESULT: begin
        if (!display) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    auth_ok_d = (state_d == S_AUTH);
    locked_d  = (state_d == S_LOCKED);
    winner_d  = (state_d == S_RESULT) ? lead_c : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fail_q     <= '0;
      tmo_q      <= '0;
      for (int i = 0; i < N_CAND; i++) tally_q[i] <= '0;
      winner_q   <= '0;
      auth_ok_q  <= 1'b0;
      locked_q   <= 1'b0;
      vote_ack_q <= 1'b0;
      vote_err_q <= 1'b0;
      pin_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      for (int i = 0; i < N_CAND; i++) tally_q[i] <= tally_d[i];
      winner_q   <= winner_d;
      auth_ok_q  <= auth_ok_d;
      locked_q   <= locked_d;
      vote_ack_q <= vote_ack_d;
      vote_err_q <= vote_err_d;
      pin_fail_q <= pin_fail_d;
    end
  end

  // Flatten tallies onto the output bus
  always_comb begin
    tally = '0;
    for (int i = 0; i < N_CAND; i++) tally[i*CNT_W +: CNT_W] = tally_q[i];
  end

  assign winner   = winner_q;
  assign auth_ok  = auth_ok_q;
  assign locked   = locked_q;
  assign vote_ack = vote_ack_q;
  assign vote_err = vote_err_q;
  assign pin_fail = pin_fail_q;

endmodule
